// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush control with load-use detection and redirect squashing
//
// Purpose:
//   Drives the PC hold, IF/ID stall and flush, and ID/EX flush for a
//   5-stage pipeline. It detects load-use hazards between ID and EX.
//   After a taken branch or jump resolves in EX, it squashes IF/ID for
//   REDIRECT_BUBBLES cycles. It also keeps two saturating performance
//   counters.
//
// Parameters:
//   REDIRECT_BUBBLES  IF/ID flush cycles per redirect (1..15)
//   COUNT_WIDTH       width of each performance counter
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high; all outputs forced to 0 while high
//   ID_Rs1/ID_Rs2   in   source registers of the instruction in ID
//   ID_UsesRs1/2    in   ID instruction actually reads that source
//   EX_MemRead      in   EX instruction is a load
//   EX_Rd           in   destination register of the EX instruction
//   EX_Redirect     in   taken branch/jal/jalr resolved in EX this cycle
//   CountClear      in   synchronous clear of both counters
//   PcStall         out  hold the PC
//   IF_ID_Stall     out  hold the IF/ID register
//   IF_ID_Flush     out  squash IF/ID contents
//   ID_EX_Flush     out  insert a bubble into ID/EX
//   StallCycles     out  load-use stall cycle count (saturating)
//   RedirectEvents  out  redirect cycle count (saturating)

module hazard_control_unit #(
   parameter int REDIRECT_BUBBLES = 2,
   parameter int COUNT_WIDTH      = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             ID_Rs1,
   input  logic [4:0]             ID_Rs2,
   input  logic                   ID_UsesRs1,
   input  logic                   ID_UsesRs2,
   input  logic                   EX_MemRead,
   input  logic [4:0]             EX_Rd,
   input  logic                   EX_Redirect,
   input  logic                   CountClear,
   output logic                   PcStall,
   output logic                   IF_ID_Stall,
   output logic                   IF_ID_Flush,
   output logic                   ID_EX_Flush,
   output logic [COUNT_WIDTH-1:0] StallCycles,
   output logic [COUNT_WIDTH-1:0] RedirectEvents
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SQUASH = 1'b1
   } state_t;

   // The redirect cycle is the first flush cycle, so SQUASH covers the rest.
   localparam logic [3:0]             BUBBLE_RELOAD = 4'(REDIRECT_BUBBLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE       = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX       = {COUNT_WIDTH{1'b1}};

   state_t                 state_q, state_d;
   logic [3:0]             bubbles_left_q, bubbles_left_d;
   logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [COUNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;

   logic src_match;
   logic lu;
   logic hold;

   // x0 is never a real producer, so a load to x0 cannot create a hazard.
   assign src_match = (ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                      (ID_UsesRs2 && (ID_Rs2 == EX_Rd));

   // In SQUASH, ID holds a bubble, and a redirect kills the ID instruction anyway.
   assign lu = EX_MemRead && (EX_Rd != 5'd0) && src_match &&
               (state_q == S_IDLE) && !EX_Redirect;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         bubbles_left_q <= 4'd0;
         stall_cnt_q    <= '0;
         redir_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         bubbles_left_q <= bubbles_left_d;
         stall_cnt_q    <= stall_cnt_d;
         redir_cnt_q    <= redir_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d        = state_q;
      bubbles_left_d = bubbles_left_q;
      if (EX_Redirect) begin
         if (REDIRECT_BUBBLES > 1) begin
            state_d        = S_SQUASH;
            bubbles_left_d = BUBBLE_RELOAD;
         end else begin
            state_d        = S_IDLE;
            bubbles_left_d = 4'd0;
         end
      end else if (state_q == S_SQUASH) begin
         bubbles_left_d = bubbles_left_q - 4'd1;
         if (bubbles_left_q <= 4'd1) begin
            state_d = S_IDLE;
         end
      end
   end

   // Output logic
   always_comb begin
      hold        = 1'b0;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      if (reset) begin
         hold = 1'b0;
      end else if (EX_Redirect) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (state_q == S_SQUASH) begin
         IF_ID_Flush = 1'b1;
      end else if (lu) begin
         hold        = 1'b1;
         ID_EX_Flush = 1'b1;
      end
   end

   // PC and IF/ID always hold together so the fetched instruction is not lost.
   assign PcStall     = hold;
   assign IF_ID_Stall = hold;

   // Saturating counters; clear wins over increment
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (CountClear) begin
         stall_cnt_d = '0;
         redir_cnt_d = '0;
      end else begin
         if (lu && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         if (EX_Redirect && (redir_cnt_q != CNT_MAX)) begin
            redir_cnt_d = redir_cnt_q + CNT_ONE;
         end
      end
   end

   assign StallCycles    = reset ? '0 : stall_cnt_q;
   assign RedirectEvents = reset ? '0 : redir_cnt_q;

endmodule
